// File: rtl/sw_pkg.sv
// Shared types and defaults for the stopwatch run controller.
// Holds the FSM state encoding and the default divider constants.
package sw_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ERROR = 2'd3
  } sw_state_t;

  // 1 s count step and 0.25 s flash half-period at 100 MHz
  localparam int unsigned SW_TICK_DIV  = 100_000_000;
  localparam int unsigned SW_BLINK_DIV = 25_000_000;

endpackage

// File: rtl/sw_prescaler.sv
// Modulo-DIV cycle counter producing a one-cycle wrap pulse.
// Ports: clk, reset (sync, active-low), en (count), clr (sync zero),
//        wrap (high in the cycle the count sits at DIV-1 and advances).
module sw_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;
  logic         at_last;

  assign at_last = (cnt == LAST);

  // A clear in the same cycle swallows the wrap.
  assign wrap = en & ~clr & at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/error sequencer for the MM:SS stopwatch datapath.
// In: clk, reset (sync, active-low), start_btn, clear_btn, up, at_limit.
// Out: count_en, count_up, cnt_clr, error, blank, state[1:0].
module stopwatch_run_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned TICK_DIV  = SW_TICK_DIV,
  parameter int unsigned BLINK_DIV = SW_BLINK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic       up,
  input  logic       at_limit,
  output logic       count_en,
  output logic       count_up,
  output logic       cnt_clr,
  output logic       error,
  output logic       blank,
  output logic [1:0] state
);

  sw_state_t state_q;

  logic in_run;
  logic in_err;
  logic mismatch;
  logic tick_en;
  logic tick_clr;
  logic tick_wrap;
  logic blink_en;
  logic blink_clr;
  logic blink_wrap;

  assign in_run   = (state_q == S_RUN);
  assign in_err   = (state_q == S_ERROR);
  assign mismatch = (up != count_up);

  // Tick counter only runs in RUN; any event that leaves RUN
  // zeroes it on the same edge so PAUSE always holds 0.
  assign tick_en  = in_run;
  assign tick_clr = clear_btn | ~in_run | mismatch
                  | at_limit | start_btn;

  // Flash counter only runs in ERROR and restarts on every entry.
  assign blink_en  = in_err;
  assign blink_clr = clear_btn | ~in_err
                   | (start_btn & ~mismatch);

  sw_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .wrap  (tick_wrap)
  );

  sw_prescaler #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (blink_en),
    .clr   (blink_clr),
    .wrap  (blink_wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_en <= 1'b0;
      count_up <= 1'b1;
      cnt_clr  <= 1'b0;
      error    <= 1'b0;
      blank    <= 1'b0;
    end else begin
      count_en <= 1'b0;
      cnt_clr  <= 1'b0;
      error    <= 1'b0;
      blank    <= 1'b0;
      if (clear_btn) begin
        state_q  <= S_IDLE;
        cnt_clr  <= 1'b1;
        count_up <= up;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_btn) begin
              state_q  <= S_RUN;
              count_up <= up;
            end
          end
          S_RUN: begin
            if (mismatch) begin
              state_q <= S_ERROR;
              error   <= 1'b1;
            end else if (at_limit) begin
              state_q <= S_PAUSE;
            end else if (start_btn) begin
              state_q <= S_PAUSE;
            end else begin
              count_en <= tick_wrap;
            end
          end
          S_PAUSE: begin
            // A start at the limit would step past it; ignore it.
            if (start_btn && !at_limit) begin
              state_q  <= S_RUN;
              count_up <= up;
            end
          end
          S_ERROR: begin
            if (start_btn && !mismatch) begin
              state_q <= S_PAUSE;
            end else begin
              error <= 1'b1;
              blank <= blank ^ blink_wrap;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Randomised scoreboard bench for stopwatch_run_ctrl.
// Reference model tracks elapsed time in each state.
module tb_stopwatch_run_ctrl;

  localparam int TICK  = 4;
  localparam int BLINK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       up = 1'b1;
  logic       at_limit = 1'b0;
  logic       count_en;
  logic       count_up;
  logic       cnt_clr;
  logic       error;
  logic       blank;
  logic [1:0] state;

  stopwatch_run_ctrl #(
    .TICK_DIV  (TICK),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_btn (start_btn),
    .clear_btn (clear_btn),
    .up        (up),
    .at_limit  (at_limit),
    .count_en  (count_en),
    .count_up  (count_up),
    .cnt_clr   (cnt_clr),
    .error     (error),
    .blank     (blank),
    .state     (state)
  );

  always #5 clk = ~clk;

  // expected: {state[1:0], count_en, count_up, cnt_clr, error, blank}
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit drive_done = 1'b0;

  // model: 0 idle, 1 run, 2 pause, 3 error
  int m_st    = 0;
  bit m_dir   = 1'b1;
  int m_run_t = 0;
  int m_err_t = 0;
  bit cur_up  = 1'b1;

  task automatic step(input bit r, input bit s, input bit c,
                      input bit u, input bit a);
    bit en;
    bit clr;
    bit bl;
    @(negedge clk);
    reset     = r;
    start_btn = s;
    clear_btn = c;
    up        = u;
    at_limit  = a;
    en  = 1'b0;
    clr = 1'b0;
    if (!r) begin
      m_st  = 0;
      m_dir = 1'b1;
    end else if (c) begin
      m_st  = 0;
      clr   = 1'b1;
      m_dir = u;
    end else begin
      case (m_st)
        0: if (s) begin
          m_st = 1; m_dir = u; m_run_t = 0;
        end
        1: if (u != m_dir) begin
          m_st = 3; m_err_t = 0;
        end else if (a || s) begin
          m_st = 2;
        end else begin
          m_run_t++;
          en = (m_run_t % TICK) == 0;
        end
        2: if (s && !a) begin
          m_st = 1; m_dir = u; m_run_t = 0;
        end
        default: if (s && u == m_dir) begin
          m_st = 2;
        end else begin
          m_err_t++;
        end
      endcase
    end
    bl = (m_st == 3) && (((m_err_t / BLINK) % 2) == 1);
    exp_q.push_back({2'(m_st), en, m_dir, clr, m_st == 3, bl});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, cur_up, 0);
  endtask

  // monitor: one output set per cycle, compared against the queue
  initial begin
    logic [6:0] got;
    logic [6:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, count_en, count_up, cnt_clr, error, blank};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL outputs t=%0t got st=%0d en=%b up=%b clr=%b err=%b bl=%b want st=%0d en=%b up=%b clr=%b err=%b bl=%b",
                   $time, got[6:5], got[4], got[3], got[2], got[1], got[0],
                   exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    // reset and first run
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    cur_up = 1'b1;
    step(1, 1, 0, 1, 0);
    idle(13);
    // pause mid-period, reverse, resume
    step(1, 1, 0, 1, 0);
    idle(5);
    step(1, 1, 0, 1, 0);
    idle(2);
    cur_up = 1'b0;
    idle(2);
    step(1, 1, 0, 0, 0);
    idle(6);
    // illegal flip while running, then restore
    cur_up = 1'b1;
    idle(9);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    // limit on a wrap cycle, then blocked start
    idle(3);
    step(1, 0, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    idle(2);
    // clear from pause, run and error; clear beats start
    step(1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    idle(2);
    step(1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    cur_up = 1'b0;
    idle(4);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    // reset during error flash
    step(1, 1, 0, 0, 0);
    cur_up = 1'b1;
    idle(5);
    step(0, 0, 1, 1, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit s;
      bit c;
      bit a;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 59) == 0);
      a = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) cur_up = ~cur_up;
      step(r, s, c, cur_up, a);
    end
    drive_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
